alu_sequencer: RTL and testbench

Initiator side of the ALU interface: accepts operation requests over a valid/ready handshake, drives the combinational ALU through the `alu_interface` initiator modport, and returns a registered result with status flags over a second valid/ready handshake. It sits between the decode/issue logic and the ALU. It turns the ALU's single-cycle combinational path into a registered, back-pressurable execute step. Optionally it sequences 64-bit operations as multiple ALU passes.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_interface.sv | 19 +
 rtl/alu.sv | 47 ++++
 rtl/alu_sequencer_dword_flags.sv | 49 ++++
 rtl/alu_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: operation encoding, status flags and the sequencer state set.
// The LO/HI/FIX states exist only when ALU_DWORD_EN is defined.
package alu_pkg;

    typedef enum logic [1:0] {
        add      = 2'b00,
        subtract = 2'b01,
        bitw_or  = 2'b10,
        bitw_and = 2'b11
    } alu_ctrl_t;

    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
    } alu_stat_t;

`ifdef ALU_DWORD_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        RESP = 3'd2,
        LO   = 3'd3,
        HI   = 3'd4,
        FIX  = 3'd5
    } seq_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;
`endif

    function automatic logic is_arith(input alu_ctrl_t op);
        return (op == add) || (op == subtract);
    endfunction

endpackage

// File: rtl/alu_interface.sv
// Connection between an ALU initiator and the combinational ALU: control and
// operands in, result and status flags back.
interface alu_interface #(parameter int WIDTH = 32);
    import alu_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_in_t;

    alu_ctrl_t        control;
    alu_in_t          in;
    logic [WIDTH-1:0] out;
    alu_stat_t        stat;

    modport initiator (output control, output in, input out, input stat);
    modport target    (input control, input in, output out, output stat);

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU: add, subtract, or, and with zero/sign/overflow.
// Overflow is signed and only meaningful for add and subtract.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    alu_interface.target io
);

    logic [WIDTH-1:0] res_s;
    logic             ovf_s;

    // Datapath result and signed overflow for the selected operation
    always_comb begin
        res_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
        case (io.control)
            add: begin
                res_s = io.in.a + io.in.b;
                ovf_s = (io.in.a[WIDTH-1] == io.in.b[WIDTH-1]) &&
                        (res_s[WIDTH-1] != io.in.a[WIDTH-1]);
            end
            subtract: begin
                res_s = io.in.a - io.in.b;
                ovf_s = (io.in.a[WIDTH-1] != io.in.b[WIDTH-1]) &&
                        (res_s[WIDTH-1] != io.in.a[WIDTH-1]);
            end
            bitw_or: begin
                res_s = io.in.a | io.in.b;
                ovf_s = 1'b0;
            end
            bitw_and: begin
                res_s = io.in.a & io.in.b;
                ovf_s = 1'b0;
            end
            default: begin
                res_s = {WIDTH{1'b0}};
                ovf_s = 1'b0;
            end
        endcase
    end

    assign io.out  = res_s;
    assign io.stat = {(res_s == {WIDTH{1'b0}}), res_s[WIDTH-1], ovf_s};

endmodule

// File: rtl/alu_sequencer_dword_flags.sv
// dword_flags: carry/borrow out of the low pass and 64-bit zero/sign/overflow
// from the two result halves. Built only with ALU_DWORD_EN.
`ifdef ALU_DWORD_EN
module dword_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_ctrl_t        op,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b_lo,
    input  logic [WIDTH-1:0] res_lo,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] b_hi,
    input  logic [WIDTH-1:0] lo_result,
    input  logic [WIDTH-1:0] hi_result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             overflow
);

    // Carry for add, borrow for subtract; overflow judged on the high words only
    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            add: begin
                carry    = (res_lo < a_lo);
                overflow = (a_hi[WIDTH-1] == b_hi[WIDTH-1]) &&
                           (hi_result[WIDTH-1] != a_hi[WIDTH-1]);
            end
            subtract: begin
                carry    = (a_lo < b_lo);
                overflow = (a_hi[WIDTH-1] != b_hi[WIDTH-1]) &&
                           (hi_result[WIDTH-1] != a_hi[WIDTH-1]);
            end
            default: begin
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (lo_result == {WIDTH{1'b0}}) && (hi_result == {WIDTH{1'b0}});
    assign sign = hi_result[WIDTH-1];

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Registered, back-pressurable execute step around the combinational ALU.
// Defining ALU_DWORD_EN adds 64-bit operations sequenced as LO/HI/[FIX] passes.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  alu_ctrl_t        req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
`ifdef ALU_DWORD_EN
    input  logic             req_dword,
    input  logic [WIDTH-1:0] req_a_hi,
    input  logic [WIDTH-1:0] req_b_hi,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
`ifdef ALU_DWORD_EN
    output logic [WIDTH-1:0] rsp_result_hi,
`endif
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_overflow,
    alu_interface.initiator  io
);

    seq_state_t       state_r;
    seq_state_t       state_next_s;
    alu_ctrl_t        op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             sign_r;
    logic             ovf_r;
    logic             rsp_valid_r;

    alu_ctrl_t        alu_op_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic             accept_s;
    logic             ld_lo_s;
    logic             ld_flags_s;
    logic             zero_next_s;
    logic             sign_next_s;
    logic             ovf_next_s;

`ifdef ALU_DWORD_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] a_hi_r;
    logic [WIDTH-1:0] b_hi_r;
    logic [WIDTH-1:0] result_hi_r;
    logic             carry_r;
    logic             ld_hi_s;
    logic             ld_carry_s;
    logic             clr_hi_s;
    logic             df_carry_s;
    logic             df_zero_s;
    logic             df_sign_s;
    logic             df_ovf_s;

    // The ALU output serves as the low result in LO and as the high result in HI/FIX
    dword_flags #(.WIDTH(WIDTH)) u_dword_flags (
        .op        (op_r),
        .a_lo      (a_r),
        .b_lo      (b_r),
        .res_lo    (io.out),
        .a_hi      (a_hi_r),
        .b_hi      (b_hi_r),
        .lo_result (result_r),
        .hi_result (io.out),
        .carry     (df_carry_s),
        .zero      (df_zero_s),
        .sign      (df_sign_s),
        .overflow  (df_ovf_s)
    );
`endif

    assign req_ready = (state_r == IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;

    // Next state, ALU drive from latched operands only, and capture strobes
    always_comb begin
        state_next_s = state_r;
        alu_op_s     = add;
        alu_a_s      = {WIDTH{1'b0}};
        alu_b_s      = {WIDTH{1'b0}};
        ld_lo_s      = 1'b0;
        ld_flags_s   = 1'b0;
        zero_next_s  = 1'b0;
        sign_next_s  = 1'b0;
        ovf_next_s   = 1'b0;
`ifdef ALU_DWORD_EN
        ld_hi_s      = 1'b0;
        ld_carry_s   = 1'b0;
        clr_hi_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef ALU_DWORD_EN
                    state_next_s = req_dword ? LO : EXEC;
`else
                    state_next_s = EXEC;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                alu_op_s     = op_r;
                alu_a_s      = a_r;
                alu_b_s      = b_r;
                ld_lo_s      = 1'b1;
                ld_flags_s   = 1'b1;
                zero_next_s  = io.stat.zero;
                sign_next_s  = io.stat.sign;
                ovf_next_s   = io.stat.overflow && is_arith(op_r);
`ifdef ALU_DWORD_EN
                clr_hi_s     = 1'b1;
`endif
                state_next_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
`ifdef ALU_DWORD_EN
            LO: begin
                alu_op_s     = op_r;
                alu_a_s      = a_r;
                alu_b_s      = b_r;
                ld_lo_s      = 1'b1;
                ld_carry_s   = 1'b1;
                state_next_s = HI;
            end
            HI: begin
                alu_op_s = op_r;
                alu_a_s  = a_hi_r;
                alu_b_s  = b_hi_r;
                ld_hi_s  = 1'b1;
                // carry_r can only be set by add/subtract, so it alone selects the fix pass
                if (carry_r) begin
                    state_next_s = FIX;
                end else begin
                    ld_flags_s   = 1'b1;
                    zero_next_s  = df_zero_s;
                    sign_next_s  = df_sign_s;
                    ovf_next_s   = df_ovf_s;
                    state_next_s = RESP;
                end
            end
            FIX: begin
                alu_op_s     = op_r;
                alu_a_s      = result_hi_r;
                alu_b_s      = ONE_W;
                ld_hi_s      = 1'b1;
                ld_flags_s   = 1'b1;
                zero_next_s  = df_zero_s;
                sign_next_s  = df_sign_s;
                ovf_next_s   = df_ovf_s;
                state_next_s = RESP;
            end
`endif
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign io.control = alu_op_s;
    assign io.in      = {alu_a_s, alu_b_s};

    // State, request latches, result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            op_r        <= add;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef ALU_DWORD_EN
            a_hi_r      <= {WIDTH{1'b0}};
            b_hi_r      <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= (state_next_s == RESP);
            if (accept_s) begin
                op_r <= req_op;
                a_r  <= req_a;
                b_r  <= req_b;
`ifdef ALU_DWORD_EN
                a_hi_r <= req_a_hi;
                b_hi_r <= req_b_hi;
`endif
            end
            if (ld_lo_s) begin
                result_r <= io.out;
            end
            if (ld_flags_s) begin
                zero_r <= zero_next_s;
                sign_r <= sign_next_s;
                ovf_r  <= ovf_next_s;
            end
`ifdef ALU_DWORD_EN
            if (ld_carry_s) begin
                carry_r <= df_carry_s;
            end
            if (ld_hi_s) begin
                result_hi_r <= io.out;
            end else if (clr_hi_s) begin
                result_hi_r <= {WIDTH{1'b0}};
            end
`endif
        end
    end

    assign rsp_valid     = rsp_valid_r;
    assign rsp_result    = result_r;
`ifdef ALU_DWORD_EN
    assign rsp_result_hi = result_hi_r;
`endif
    assign rsp_zero      = zero_r;
    assign rsp_sign      = sign_r;
    assign rsp_overflow  = ovf_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer driving the real alu through one alu_interface; the
// expected results come from a plain-arithmetic model. ALU_DWORD_EN adds dword tests.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        sign;
        logic        ovf;
        int          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    alu_ctrl_t        req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_sign;
    logic             rsp_overflow;
`ifdef ALU_DWORD_EN
    logic             req_dword;
    logic [WIDTH-1:0] req_a_hi;
    logic [WIDTH-1:0] req_b_hi;
    logic [WIDTH-1:0] rsp_result_hi;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_interface #(.WIDTH(WIDTH)) alu_if ();

    alu #(.WIDTH(WIDTH)) u_alu (.io(alu_if));

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
`ifdef ALU_DWORD_EN
        .req_dword    (req_dword),
        .req_a_hi     (req_a_hi),
        .req_b_hi     (req_b_hi),
        .rsp_result_hi(rsp_result_hi),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_sign     (rsp_sign),
        .rsp_overflow (rsp_overflow),
        .io           (alu_if)
    );

    // Reference: 32-bit ops via signed 64-bit arithmetic, 64-bit ops via 65-bit arithmetic
    function automatic exp_t model(input alu_ctrl_t op, input logic dw,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        longint sa, sb, r;
        logic signed [64:0] ea, eb, er;
        logic [32:0] lo_sum;
        e.ovf = 1'b0;
        if (!dw) begin
            sa = longint'($signed(a[31:0]));
            sb = longint'($signed(b[31:0]));
            case (op)
                add:      r = sa + sb;
                subtract: r = sa - sb;
                bitw_or:  r = longint'($signed(a[31:0] | b[31:0]));
                default:  r = longint'($signed(a[31:0] & b[31:0]));
            endcase
            e.res  = {32'h0, r[31:0]};
            e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            e.zero = (r[31:0] == 32'h0);
            e.sign = r[31];
            e.lat  = 1;
        end else begin
            ea = $signed({a[63], a});
            eb = $signed({b[63], b});
            lo_sum = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            e.lat = 2;
            case (op)
                add: begin
                    er = ea + eb;
                    e.ovf = (er[64] != er[63]);
                    if (lo_sum[32]) e.lat = 3;
                end
                subtract: begin
                    er = ea - eb;
                    e.ovf = (er[64] != er[63]);
                    if (a[31:0] < b[31:0]) e.lat = 3;
                end
                bitw_or: er = {1'b0, a | b};
                default: er = {1'b0, a & b};
            endcase
            e.res  = er[63:0];
            e.zero = (er[63:0] == 64'h0);
            e.sign = er[63];
        end
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
                0:       return 32'h0000_0000;
                1:       return 32'hFFFF_FFFF;
                2:       return 32'h7FFF_FFFF;
                default: return 32'h8000_0000;
            endcase
        end
        return $urandom;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_ctrl_t op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (req_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = add;
        req_a     = 32'h0;
        req_b     = 32'h0;
`ifdef ALU_DWORD_EN
        req_dword = 1'b0;
        req_a_hi  = 32'h0;
        req_b_hi  = 32'h0;
`endif
        repeat (3) step();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
        end
        tests_run++;
        if (rsp_result !== 32'h0 || {rsp_zero, rsp_sign, rsp_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_result_flags: got %h/%b required 0/000",
                     rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_ready_in_rst: got %b required 0", req_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready_after: got %b required 1", req_ready);
        end
    endtask

    task automatic test_add_overflow();
        int lat;
        issue(add, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL add_ovf_latency: got %0d required 1", lat);
        end
        tests_run++;
        if (rsp_result !== 32'h8000_0000 || {rsp_zero, rsp_sign, rsp_overflow} !== 3'b011) begin
            tests_failed++;
            $display("FAIL add_ovf_value: got %h zso=%b required 80000000 zso=011",
                     rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(subtract, 32'd5, 32'd5);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL sub_bp_latency: got %0d required 1", lat);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({rsp_valid, req_ready, rsp_zero, rsp_sign, rsp_overflow} !== 5'b10100 ||
                rsp_result !== 32'h0) begin
                tests_failed++;
                $display("FAIL sub_bp_hold%0d: valid/ready/zso=%b result=%h required 10100 result=0",
                         i, {rsp_valid, req_ready, rsp_zero, rsp_sign, rsp_overflow}, rsp_result);
            end
            step();
        end
        consume();
        tests_run++;
        if ({rsp_valid, req_ready} !== 2'b01 || rsp_result !== 32'h0 || rsp_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_bp_release: valid/ready=%b result=%h zero=%b required 01 0 1",
                     {rsp_valid, req_ready}, rsp_result, rsp_zero);
        end
    endtask

    task automatic test_logic();
        int lat;
        issue(bitw_and, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 1 || rsp_result !== 32'h0 || {rsp_zero, rsp_sign, rsp_overflow} !== 3'b100) begin
            tests_failed++;
            $display("FAIL logic_and: lat=%0d result=%h zso=%b required 1 0 100",
                     lat, rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        consume();
        issue(bitw_or, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 1 || rsp_result !== 32'hFFFF_FFFF || {rsp_zero, rsp_sign, rsp_overflow} !== 3'b010) begin
            tests_failed++;
            $display("FAIL logic_or: lat=%0d result=%h zso=%b required 1 ffffffff 010",
                     lat, rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        consume();
    endtask

    task automatic test_reset_mid_op();
        issue(add, 32'd1, 32'd2);
        rst = 1'b1;
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || {rsp_zero, rsp_sign, rsp_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_op: valid=%b result=%h zso=%b required 0 0 000",
                     rsp_valid, rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_op_ready: got %b required 1", req_ready);
        end
        repeat (3) step();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_discard: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

`ifdef ALU_DWORD_EN
    task automatic test_dword_carry();
        int lat;
        req_dword = 1'b1;
        req_a_hi  = 32'h0;
        req_b_hi  = 32'h0;
        issue(add, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 3 || rsp_result !== 32'h0 || rsp_result_hi !== 32'h1 ||
            {rsp_zero, rsp_sign, rsp_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL dword_carry: lat=%0d hi=%h lo=%h zso=%b required 3 1 0 000",
                     lat, rsp_result_hi, rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        consume();
        req_dword = 1'b0;
    endtask

    task automatic test_dword_borrow();
        int lat;
        req_dword = 1'b1;
        req_a_hi  = 32'h8000_0000;
        req_b_hi  = 32'h0;
        issue(subtract, 32'h0, 32'h0000_0001);
        wait_rsp(lat);
        tests_run++;
        if (lat !== 3 || rsp_result !== 32'hFFFF_FFFF || rsp_result_hi !== 32'h7FFF_FFFF ||
            {rsp_zero, rsp_sign, rsp_overflow} !== 3'b001) begin
            tests_failed++;
            $display("FAIL dword_borrow: lat=%0d hi=%h lo=%h zso=%b required 3 7fffffff ffffffff 001",
                     lat, rsp_result_hi, rsp_result, {rsp_zero, rsp_sign, rsp_overflow});
        end
        consume();
        req_dword = 1'b0;
    endtask
`endif

    task automatic test_random();
        int lat;
        exp_t e;
        alu_ctrl_t op;
        logic dw;
        logic [63:0] a, b;
        logic [31:0] got_hi;
        for (int i = 0; i < 40; i++) begin
            op = alu_ctrl_t'(2'($urandom_range(0, 3)));
            a  = {pick_operand(), pick_operand()};
            b  = {pick_operand(), pick_operand()};
            dw = 1'b0;
`ifdef ALU_DWORD_EN
            dw        = 1'($urandom_range(0, 1));
            req_dword = dw;
            req_a_hi  = a[63:32];
            req_b_hi  = b[63:32];
`endif
            if (!dw) begin
                a[63:32] = 32'h0;
                b[63:32] = 32'h0;
            end
            e = model(op, dw, a, b);
            issue(op, a[31:0], b[31:0]);
            wait_rsp(lat);
            repeat ($urandom_range(0, 3)) step();
            got_hi = 32'h0;
`ifdef ALU_DWORD_EN
            got_hi = rsp_result_hi;
`endif
            tests_run++;
            if (lat !== e.lat || {got_hi, rsp_result} !== e.res ||
                {rsp_zero, rsp_sign, rsp_overflow} !== {e.zero, e.sign, e.ovf}) begin
                tests_failed++;
                $display("FAIL random%0d op=%0d dw=%b: lat=%0d res=%h zso=%b required lat=%0d res=%h zso=%b",
                         i, op, dw, lat, {got_hi, rsp_result}, {rsp_zero, rsp_sign, rsp_overflow},
                         e.lat, e.res, {e.zero, e.sign, e.ovf});
            end
            consume();
        end
`ifdef ALU_DWORD_EN
        req_dword = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        alu_ctrl_t ops[5];
        logic [31:0] av[5];
        logic [31:0] bv[5];
        int acc = 0;
        int got = 0;
        int cyc = 0;
        int last_acc = -1;
        bit taking;
        for (int i = 0; i < 5; i++) begin
            ops[i] = alu_ctrl_t'(2'($urandom_range(0, 3)));
            av[i]  = pick_operand();
            bv[i]  = pick_operand();
        end
        rsp_ready = 1'b1;
        req_op    = ops[0];
        req_a     = av[0];
        req_b     = bv[0];
        req_valid = 1'b1;
        while (got < 5 && cyc < 200) begin
            taking = (req_valid === 1'b1) && (req_ready === 1'b1);
            if (rsp_valid === 1'b1) begin
                tests_run++;
                if (q.size() == 0 || rsp_result !== q[0].res[31:0] ||
                    {rsp_zero, rsp_sign, rsp_overflow} !== {q[0].zero, q[0].sign, q[0].ovf}) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp%0d: res=%h zso=%b (expected entries %0d)",
                             got, rsp_result, {rsp_zero, rsp_sign, rsp_overflow}, q.size());
                end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (taking) begin
                q.push_back(model(ops[acc], 1'b0, {32'h0, av[acc]}, {32'h0, bv[acc]}));
                if (last_acc >= 0) begin
                    tests_run++;
                    if (cyc - last_acc !== 3) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles required 3", acc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                acc++;
            end
            step();
            cyc++;
            if (taking) begin
                if (acc < 5) begin
                    req_op = ops[acc];
                    req_a  = av[acc];
                    req_b  = bv[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tests_run++;
        if (got !== 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d responses required 5", got);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_backpressure();
        test_logic();
        test_reset_mid_op();
`ifdef ALU_DWORD_EN
        test_dword_carry();
        test_dword_borrow();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
